// File: rtl/lfsr_random_source.sv
// -----------------------------------------------------------------------------
// lfsr_random_source
//
// Purpose:
//   Pseudo-random value source built around a right-shift Galois LFSR. Each
//   request advances the LFSR STEPS_PER_DRAW times, then presents the stepped
//   value on randomNumber behind a request/valid/ack handshake. The consumer
//   is the value randomizer stage in the game control path.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   asynchronous active-low reset
//   seed_load    in   one-cycle strobe: reseed the LFSR from seed_in
//   seed_in      in   [WIDTH] seed value (zero is replaced by DEFAULT_SEED)
//   rnd_req      in   request a new random value
//   rnd_ack      in   consumer has taken randomNumber
//   randomNumber out  [WIDTH] registered random value, stable while rnd_valid
//   rnd_valid    out  randomNumber holds a fresh, unconsumed value
//   busy         out  draw in progress
//
// Build option:
//   FREE_RUN_EN  when defined, the LFSR also steps every cycle in IDLE and
//                VALID so draws depend on request timing. When undefined the
//                LFSR only moves during a draw and the output sequence is
//                fully determined by the seed.
// -----------------------------------------------------------------------------
module lfsr_random_source #(
    parameter int                 WIDTH          = 16,
    parameter logic [WIDTH-1:0]   TAPS           = 16'hB400,
    parameter logic [WIDTH-1:0]   DEFAULT_SEED   = 16'hACE1,
    parameter int                 STEPS_PER_DRAW = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             rnd_req,
    input  logic             rnd_ack,
    output logic [WIDTH-1:0] randomNumber,
    output logic             rnd_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam logic [7:0] STEPS = 8'(STEPS_PER_DRAW);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] rnd_q, rnd_d;
    logic [WIDTH-1:0] lfsr_stepped;

    // One LFSR advance. An all-zero register would lock up forever, so it is
    // replaced by DEFAULT_SEED instead of being stepped.
    always_comb begin
        if (lfsr_q == '0) begin
            lfsr_stepped = DEFAULT_SEED;
        end else begin
            lfsr_stepped = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        rnd_d   = rnd_q;
`ifdef FREE_RUN_EN
        // Free-running: entropy from player timing; STEP steps identically.
        lfsr_d  = lfsr_stepped;
`endif
        if (seed_load) begin
            // Reseed wins over everything and aborts any draw; the last
            // delivered value stays on randomNumber.
            lfsr_d  = (seed_in == '0) ? DEFAULT_SEED : seed_in;
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rnd_req) begin
                        state_d = STEP;
                        cnt_d   = STEPS;
                    end
                end
                STEP: begin
                    lfsr_d = lfsr_stepped;
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        rnd_d   = lfsr_stepped;
                        state_d = VALID;
                    end
                end
                VALID: begin
                    // Value is held until acknowledged; a request in the
                    // same cycle as the ack starts the next draw directly.
                    if (rnd_ack) begin
                        if (rnd_req) begin
                            state_d = STEP;
                            cnt_d   = STEPS;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            lfsr_q  <= DEFAULT_SEED;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            rnd_q   <= rnd_d;
        end
    end

    assign randomNumber = rnd_q;
    assign rnd_valid    = (state_q == VALID);
    assign busy         = (state_q == STEP);

endmodule

// File: tb/tb_lfsr_random_source.sv
// -----------------------------------------------------------------------------
// tb_lfsr_random_source
//
// Bench for lfsr_random_source in its deterministic build (FREE_RUN_EN
// undefined), default parameters. A transaction-level model predicts every
// draw result up front (N LFSR steps from the current state) and schedules
// its delivery N cycles after acceptance; a compare process checks busy,
// rnd_valid and randomNumber on every falling edge.
// -----------------------------------------------------------------------------
module tb_lfsr_random_source;

    localparam int          N      = 4;
    localparam logic [15:0] TAPS   = 16'hB400;
    localparam logic [15:0] DEFSD  = 16'hACE1;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic        rnd_req = 1'b0;
    logic        rnd_ack = 1'b0;
    logic [15:0] randomNumber;
    logic        rnd_valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    lfsr_random_source #(
        .WIDTH(16), .TAPS(TAPS), .DEFAULT_SEED(DEFSD), .STEPS_PER_DRAW(N)
    ) dut (
        .CLK(CLK), .RST(RST), .seed_load(seed_load), .seed_in(seed_in),
        .rnd_req(rnd_req), .rnd_ack(rnd_ack), .randomNumber(randomNumber),
        .rnd_valid(rnd_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Value reached after n applications of the LFSR rule (zero is reseeded).
    function automatic logic [15:0] advance(input logic [15:0] v, input int n);
        logic [15:0] x;
        x = v;
        for (int i = 0; i < n; i++) begin
            if (x == 16'h0000) x = DEFSD;
            else               x = (x >> 1) ^ ((x[0] == 1'b1) ? TAPS : 16'h0000);
        end
        return x;
    endfunction

    // ---------------- transaction-level model ----------------
    logic [15:0] m_lfsr, m_pending, m_value;
    int          m_left;   // cycles until the pending draw is delivered
    bit          m_valid;

    always @(posedge CLK) begin
        if (!RST) begin
            m_lfsr  = DEFSD;
            m_value = 16'h0000;
            m_left  = 0;
            m_valid = 0;
        end else if (seed_load) begin
            m_lfsr  = (seed_in == 16'h0000) ? DEFSD : seed_in;
            m_left  = 0;
            m_valid = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1;
                m_value = m_pending;
                m_lfsr  = m_pending;
            end
        end else if (rnd_req && (!m_valid || rnd_ack)) begin
            m_valid   = 0;
            m_pending = advance(m_lfsr, N);
            m_left    = N;
        end else if (m_valid && rnd_ack) begin
            m_valid = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (!RST) begin
            chk("rst_busy",  32'(busy), 32'd0);
            chk("rst_valid", 32'(rnd_valid), 32'd0);
            chk("rst_value", 32'(randomNumber), 32'd0);
        end else begin
            chk("busy",  32'(busy), 32'(m_left > 0));
            chk("valid", 32'(rnd_valid), 32'(m_valid));
            chk("value", 32'(randomNumber), 32'(m_value));
        end
    end

    // Called one falling edge after the accepting edge.
    task automatic finish_draw(input string tag, input logic [15:0] exp, input bit do_ack);
        int k;
        int nb;
        k  = 1;
        nb = busy ? 1 : 0;
        while (!rnd_valid && k < 40) begin
            @(negedge CLK);
            k++;
            if (busy) nb++;
        end
        chk({tag, "_timeout"}, 32'(rnd_valid), 32'd1);
        chk({tag, "_latency"}, 32'(k - 1), 32'(N));
        chk({tag, "_busycyc"}, 32'(nb), 32'(N));
        chk({tag, "_value"},   32'(randomNumber), 32'(exp));
        $display("draw %s: value=%h latency=%0d busy_cycles=%0d", tag, randomNumber, k - 1, nb);
        if (do_ack) begin
            rnd_ack = 1'b1;
            @(negedge CLK);
            rnd_ack = 1'b0;
            chk({tag, "_acked"}, 32'(rnd_valid), 32'd0);
        end
    endtask

    task automatic draw(input string tag, input logic [15:0] exp, input bit do_ack);
        rnd_req = 1'b1;
        @(negedge CLK);
        rnd_req = 1'b0;
        finish_draw(tag, exp, do_ack);
    endtask

    initial begin
        // Model pins: hand-stepped values (E270,7138,389C,1C4E etc.).
        chk("pin_ace1", 32'(advance(16'hACE1, 4)), 32'h1C4E);
        chk("pin_1c4e", 32'(advance(16'h1C4E, 4)), 32'hC2C4);
        chk("pin_0001", 32'(advance(16'h0001, 4)), 32'h1680);
        chk("pin_zero", 32'(advance(16'h0000, 1)), 32'hACE1);

        #2;
        chk("init_busy",  32'(busy), 32'd0);
        chk("init_valid", 32'(rnd_valid), 32'd0);
        chk("init_value", 32'(randomNumber), 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Single draw from the reset seed.
        draw("d1", 16'h1C4E, 1'b0);

        // Unacknowledged value must hold even while requests arrive.
        for (int i = 0; i < 10; i++) begin
            rnd_req = i[0];
            @(negedge CLK);
            chk("hold_valid", 32'(rnd_valid), 32'd1);
            chk("hold_value", 32'(randomNumber), 32'h1C4E);
            chk("hold_busy",  32'(busy), 32'd0);
        end
        rnd_req = 1'b0;
        $display("hold: value=%h valid=%0d after 10 unacked cycles", randomNumber, rnd_valid);

        // Ack and request together: back-to-back draw without an idle cycle.
        rnd_ack = 1'b1;
        rnd_req = 1'b1;
        @(negedge CLK);
        rnd_ack = 1'b0;
        rnd_req = 1'b0;
        chk("b2b_valid", 32'(rnd_valid), 32'd0);
        chk("b2b_busy",  32'(busy), 32'd1);
        finish_draw("d2", 16'hC2C4, 1'b1);

        // Zero seed falls back to DEFAULT_SEED.
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        @(negedge CLK);
        seed_load = 1'b0;
        $display("seed_load: seed=0000");
        draw("d3", 16'h1C4E, 1'b1);

        // Reseed in the middle of a draw aborts it.
        rnd_req = 1'b1;
        @(negedge CLK);
        rnd_req = 1'b0;
        @(negedge CLK);
        seed_load = 1'b1;
        seed_in   = 16'h0001;
        @(negedge CLK);
        seed_load = 1'b0;
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_valid", 32'(rnd_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("abort_novalid", 32'(rnd_valid), 32'd0);
        end
        $display("seed_load mid-draw: seed=0001 busy=%0d valid=%0d", busy, rnd_valid);
        draw("d4", 16'h1680, 1'b1);

        // Asynchronous reset while a value is waiting.
        draw("d5", advance(16'h1680, 4), 1'b0);
        #2;
        RST = 1'b0;
        #1;
        chk("async_valid", 32'(rnd_valid), 32'd0);
        chk("async_busy",  32'(busy), 32'd0);
        chk("async_value", 32'(randomNumber), 32'd0);
        $display("async reset: value=%h valid=%0d busy=%0d", randomNumber, rnd_valid, busy);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        draw("d6", 16'h1C4E, 1'b1);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rnd_req   = ($urandom_range(0, 2) == 0);
            rnd_ack   = ($urandom_range(0, 3) == 0);
            seed_load = ($urandom_range(0, 63) == 0);
            seed_in   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            @(negedge CLK);
            if (rnd_valid && rnd_ack)
                $display("rand draw: value=%h", randomNumber);
        end
        rnd_req   = 1'b0;
        rnd_ack   = 1'b0;
        seed_load = 1'b0;
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
